// File: rtl/vend_dispense_ctrl_if.sv
// Coin-acceptor / dispenser signal bundle for the guffin vending controller.
// Handshake: each dispense request (guffin, quarter_out, halfDollar_out) is a level held
// until disp_ack is sampled high on a rising edge; the request drops on the following cycle.
interface vend_dispense_ctrl_if;
  logic       quarter_in;
  logic       halfDollar_in;
  logic       dollar_in;
  logic       cancel;
  logic       disp_ack;
  logic       guffin;
  logic       quarter_out;
  logic       halfDollar_out;
  logic       coin_reject;
  logic       fault;
  logic [3:0] credit;
  logic       state_high;
  logic       state_low;

  modport master (
    output quarter_in, halfDollar_in, dollar_in, cancel, disp_ack,
    input  guffin, quarter_out, halfDollar_out, coin_reject, fault, credit,
           state_high, state_low
  );

  modport slave (
    input  quarter_in, halfDollar_in, dollar_in, cancel, disp_ack,
    output guffin, quarter_out, halfDollar_out, coin_reject, fault, credit,
           state_high, state_low
  );
endinterface

// File: rtl/vend_dispense_ctrl.sv
// Guffin vending controller: credits coins, requests a guffin at PRICE, pays change
// one coin at a time, and latches a fault when the dispenser stops acknowledging.
module vend_dispense_ctrl #(
  parameter int PRICE   = 3,
  parameter int TIMEOUT = 1000
) (
  input  logic                 CLK,
  input  logic                 RES,
  vend_dispense_ctrl_if.slave  bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    COLLECT = 2'b00,
    VEND    = 2'b01,
    CHANGE  = 2'b10,
    FAULT   = 2'b11
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      credit, credit_nxt;
  logic            guffin, guffin_nxt;
  logic            q_req, q_req_nxt;
  logic            h_req, h_req_nxt;
  logic            reject, reject_nxt;
  logic            fault, fault_nxt;
  logic [CW-1:0]   wait_cnt, wait_cnt_nxt;

  logic [1:0]      coin_cnt;
  logic [3:0]      coin_val;
  logic [3:0]      sum;
  logic [3:0]      change_amt;
  logic            any_coin;
  logic            timed_out;

  assign coin_cnt   = 2'(bus.quarter_in) + 2'(bus.halfDollar_in) + 2'(bus.dollar_in);
  // One-hot coin pulses map directly onto their quarter-unit values 1/2/4.
  assign coin_val   = {1'b0, bus.dollar_in, bus.halfDollar_in, bus.quarter_in};
  assign sum        = credit + coin_val;
  assign any_coin   = (coin_cnt != 2'd0);
  assign change_amt = h_req ? 4'd2 : 4'd1;
  assign timed_out  = (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (RES) begin
      state    <= COLLECT;
      credit   <= 4'd0;
      guffin   <= 1'b0;
      q_req    <= 1'b0;
      h_req    <= 1'b0;
      reject   <= 1'b0;
      fault    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      credit   <= credit_nxt;
      guffin   <= guffin_nxt;
      q_req    <= q_req_nxt;
      h_req    <= h_req_nxt;
      reject   <= reject_nxt;
      fault    <= fault_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    credit_nxt   = credit;
    guffin_nxt   = guffin;
    q_req_nxt    = q_req;
    h_req_nxt    = h_req;
    reject_nxt   = 1'b0;
    fault_nxt    = fault;
    wait_cnt_nxt = wait_cnt;

    case (state)
      COLLECT: begin
        if (coin_cnt == 2'd1) begin
          if (sum >= 4'(PRICE)) begin
            state_nxt    = VEND;
            credit_nxt   = sum - 4'(PRICE);
            guffin_nxt   = 1'b1;
            wait_cnt_nxt = '0;
          end else begin
            credit_nxt = sum;
          end
        end else if (any_coin) begin
          reject_nxt = 1'b1;
        end else if (bus.cancel && credit != 4'd0) begin
          state_nxt    = CHANGE;
          h_req_nxt    = (credit >= 4'd2);
          q_req_nxt    = (credit < 4'd2);
          wait_cnt_nxt = '0;
        end
      end

      VEND: begin
        reject_nxt = any_coin;
        if (bus.disp_ack) begin
          guffin_nxt = 1'b0;
          if (credit != 4'd0) begin
            state_nxt    = CHANGE;
            h_req_nxt    = (credit >= 4'd2);
            q_req_nxt    = (credit < 4'd2);
            wait_cnt_nxt = '0;
          end else begin
            state_nxt = COLLECT;
          end
        end else if (timed_out) begin
          state_nxt  = FAULT;
          guffin_nxt = 1'b0;
          fault_nxt  = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + CW'(1);
        end
      end

      CHANGE: begin
        reject_nxt = any_coin;
        if (!(q_req || h_req)) begin
          // Idle gap after a paid coin: disp_ack is ignored, next coin requested.
          h_req_nxt    = (credit >= 4'd2);
          q_req_nxt    = (credit < 4'd2);
          wait_cnt_nxt = '0;
        end else if (bus.disp_ack) begin
          q_req_nxt  = 1'b0;
          h_req_nxt  = 1'b0;
          credit_nxt = credit - change_amt;
          if (credit == change_amt) begin
            state_nxt = COLLECT;
          end
        end else if (timed_out) begin
          state_nxt = FAULT;
          q_req_nxt = 1'b0;
          h_req_nxt = 1'b0;
          fault_nxt = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + CW'(1);
        end
      end

      default: begin
        reject_nxt = any_coin;
      end
    endcase
  end

  assign bus.guffin         = guffin;
  assign bus.quarter_out    = q_req;
  assign bus.halfDollar_out = h_req;
  assign bus.coin_reject    = reject;
  assign bus.fault          = fault;
  assign bus.credit         = credit;
  assign bus.state_high     = state[1];
  assign bus.state_low      = state[0];
endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Bench for vend_dispense_ctrl: transaction-level vending model compared every cycle,
// directed scenarios with literal expectations, then randomized coin/ack traffic.
module tb_vend_dispense_ctrl;
  localparam int PR = 3;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   check_en = 1'b0;

  vend_dispense_ctrl_if bus();

  vend_dispense_ctrl #(.PRICE(PR), .TIMEOUT(TO)) dut (
    .CLK (clk),
    .RES (rst),
    .bus (bus.slave)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // m_state uses the externally visible state code; m_req: 0 none, 1 guffin, 2 quarter, 3 half.
  int m_state  = 0;
  int m_credit = 0;
  int m_req    = 0;
  int m_wait   = 0;
  bit m_rej    = 1'b0;
  bit m_fault  = 1'b0;

  task automatic start_req(input int kind);
    m_req  = kind;
    m_wait = 0;
  endtask

  always @(posedge clk) begin : model
    int n;
    int v;
    n = int'(bus.quarter_in) + int'(bus.halfDollar_in) + int'(bus.dollar_in);
    v = int'(bus.quarter_in) * 1 + int'(bus.halfDollar_in) * 2 + int'(bus.dollar_in) * 4;
    m_rej = 1'b0;
    if (rst) begin
      m_state = 0; m_credit = 0; m_req = 0; m_wait = 0; m_fault = 1'b0;
    end else if (m_state == 0) begin
      if (n == 1) begin
        if (m_credit + v >= PR) begin
          m_credit = m_credit + v - PR;
          m_state  = 1;
          start_req(1);
        end else begin
          m_credit = m_credit + v;
        end
      end else if (n > 1) begin
        m_rej = 1'b1;
      end else if (bus.cancel && m_credit > 0) begin
        m_state = 2;
        start_req(m_credit >= 2 ? 3 : 2);
      end
    end else if (m_state == 3) begin
      m_rej = (n > 0);
    end else begin
      m_rej = (n > 0);
      if (m_req == 0) begin
        start_req(m_credit >= 2 ? 3 : 2);
      end else if (bus.disp_ack) begin
        if (m_req == 1) begin
          m_req = 0;
          if (m_credit > 0) begin
            m_state = 2;
            start_req(m_credit >= 2 ? 3 : 2);
          end else begin
            m_state = 0;
          end
        end else begin
          m_credit = m_credit - ((m_req == 3) ? 2 : 1);
          m_req    = 0;
          if (m_credit == 0) m_state = 0;
        end
      end else begin
        m_wait = m_wait + 1;
        if (m_wait == TO) begin
          m_state = 3; m_req = 0; m_fault = 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("state",          int'({bus.state_high, bus.state_low}), m_state);
      check("credit",         int'(bus.credit), m_credit);
      check("guffin",         int'(bus.guffin), int'(m_req == 1));
      check("quarter_out",    int'(bus.quarter_out), int'(m_req == 2));
      check("halfDollar_out", int'(bus.halfDollar_out), int'(m_req == 3));
      check("coin_reject",    int'(bus.coin_reject), int'(m_rej));
      check("fault",          int'(bus.fault), int'(m_fault));
      check("one_request",    int'(bus.guffin) + int'(bus.quarter_out) + int'(bus.halfDollar_out),
            int'(m_req != 0));
    end
  end

  // ---------------- driver ----------------
  // Holds the given inputs across exactly one rising edge, returning #1 after it.
  task automatic tick(input bit r, input bit q, input bit h, input bit d,
                      input bit c, input bit a);
    rst               = r;
    bus.quarter_in    = q;
    bus.halfDollar_in = h;
    bus.dollar_in     = d;
    bus.cancel        = c;
    bus.disp_ack      = a;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(); tick(0, 0, 0, 0, 0, 0); endtask
  task automatic ack();  tick(0, 0, 0, 0, 0, 1); endtask

  function automatic int st();
    return int'({bus.state_high, bus.state_low});
  endfunction

  initial begin
    bus.quarter_in = 0; bus.halfDollar_in = 0; bus.dollar_in = 0;
    bus.cancel = 0; bus.disp_ack = 0;
    #2;
    tick(1, 0, 0, 0, 0, 0);
    check_en = 1'b1;
    check("rst_state",  st(), 0);
    check("rst_credit", int'(bus.credit), 0);
    check("rst_outs",   int'({bus.guffin, bus.quarter_out, bus.halfDollar_out,
                              bus.coin_reject, bus.fault}), 0);

    // three quarters
    tick(0, 1, 0, 0, 0, 0); check("q1_credit", int'(bus.credit), 1);
    tick(0, 1, 0, 0, 0, 0); check("q2_credit", int'(bus.credit), 2);
    tick(0, 1, 0, 0, 0, 0); check("q3_state", st(), 1);
    check("q3_guffin", int'(bus.guffin), 1);
    idle();                 check("q3_hold", int'(bus.guffin), 1);
    ack();                  check("q3_done_state", st(), 0);
    check("q3_done_guffin", int'(bus.guffin), 0);

    // dollar with change
    tick(0, 0, 0, 1, 0, 0); check("d_credit", int'(bus.credit), 1);
    check("d_state", st(), 1);
    ack();                  check("d_change_state", st(), 2);
    check("d_quarter_out", int'(bus.quarter_out), 1);
    ack();                  check("d_end_credit", int'(bus.credit), 0);
    check("d_end_state", st(), 0);

    // half-dollar then cancel
    tick(0, 0, 1, 0, 0, 0); check("h_credit", int'(bus.credit), 2);
    tick(0, 0, 0, 0, 1, 0); check("cancel_state", st(), 2);
    check("cancel_half", int'(bus.halfDollar_out), 1);
    ack();                  check("cancel_end_credit", int'(bus.credit), 0);
    check("cancel_end_state", st(), 0);

    // rejects
    tick(0, 1, 0, 1, 0, 0); check("multi_reject", int'(bus.coin_reject), 1);
    check("multi_credit", int'(bus.credit), 0);
    idle();                 check("reject_pulse", int'(bus.coin_reject), 0);
    tick(0, 0, 0, 1, 0, 0);
    tick(0, 1, 0, 0, 0, 0); check("vend_reject", int'(bus.coin_reject), 1);
    check("vend_reject_credit", int'(bus.credit), 1);
    ack(); ack(); idle();   check("vend_reject_end", st(), 0);

    // timeout to fault, then reset
    tick(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < TO - 1; i++) begin
      idle(); check("to_guffin_hold", int'(bus.guffin), 1);
    end
    idle();
    check("to_state", st(), 3);
    check("to_fault", int'(bus.fault), 1);
    check("to_credit", int'(bus.credit), 1);
    check("to_guffin", int'(bus.guffin), 0);
    tick(1, 0, 0, 0, 0, 0);
    check("to_rst_state", st(), 0);
    check("to_rst_all", int'({bus.credit, bus.guffin, bus.fault}), 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      tick($urandom_range(99) < 2, $urandom_range(99) < 15, $urandom_range(99) < 12,
           $urandom_range(99) < 10, $urandom_range(99) < 12, $urandom_range(99) < 45);
    end

    idle();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vend_dispense_ctrl.md
VEND_DISPENSE_CTRL -- requirements
Module: vend_dispense_ctrl

Interface
REQ-001 SHALL have parameter PRICE, default 3, meaning guffin price in quarter units (1..4).
REQ-002 SHALL have parameter TIMEOUT, default 1000, meaning max cycles a dispense request waits for disp_ack (>=2).
REQ-003 SHALL have one clock; reset is synchronous and active-high: CLK  input  1  rising-edge clock.
REQ-004 RES  input  1  synchronous active-high reset.
REQ-005 quarter_in  input  1  single-cycle pulse: quarter inserted (debounced, edge-detected upstream).
REQ-006 halfDollar_in  input  1  single-cycle pulse: half-dollar inserted.
REQ-007 dollar_in  input  1  single-cycle pulse: dollar inserted.
REQ-008 cancel  input  1  single-cycle pulse: refund request.
REQ-009 disp_ack  input  1  dispenser acknowledge for the current request.
REQ-010 guffin  output  1  dispense-guffin request, level.
REQ-011 quarter_out  output  1  dispense-quarter request, level.
REQ-012 halfDollar_out  output  1  dispense-half-dollar request, level.
REQ-013 coin_reject  output  1  one-cycle pulse: inserted coin not credited.
REQ-014 fault  output  1  dispenser timeout latched.
REQ-015 credit  output  4  current credit, quarter units.
REQ-016 state_high, state_low  output  1 each  state code: COLLECT=00, VEND=01, CHANGE=10, FAULT=11.

Function
REQ-017 All outputs SHALL be registered; coin values SHALL be quarter=1, halfDollar=2, dollar=4 units.
REQ-018 COLLECT, exactly one coin pulse high: sum = credit+value; if sum>=PRICE -> VEND with credit=sum-PRICE, else stay with credit=sum.
REQ-019 COLLECT, two or more coin pulses in one cycle: none credited, coin_reject=1 next cycle.
REQ-020 Any coin pulse in VEND, CHANGE or FAULT: not credited, coin_reject=1 next cycle.
REQ-021 COLLECT, cancel with credit>0 and no coin: -> CHANGE, credit unchanged; cancel with credit=0: ignored.
REQ-022 Coin and cancel in the same COLLECT cycle: coin processed per REQ-018/019, cancel ignored.
REQ-023 VEND: guffin=1 from the first VEND cycle until disp_ack sampled high; then guffin=0 next cycle and -> CHANGE if credit>0 else COLLECT.
REQ-024 CHANGE: request halfDollar_out if credit>=2, else quarter_out; exactly one request high at a time.
REQ-025 CHANGE: on disp_ack sampled high, request drops next cycle and credit decrements by 2 (half) or 1 (quarter).
REQ-026 CHANGE: at least one idle cycle (all requests low) between consecutive coin requests.
REQ-027 CHANGE: when credit reaches 0 -> COLLECT in the same cycle the request drops.
REQ-028 disp_ack SHALL be ignored in COLLECT, FAULT, and in CHANGE idle-gap cycles.
REQ-029 Wait counter SHALL clear on every new request and count cycles a request is high without ack.
REQ-030 Counter reaching TIMEOUT: -> FAULT, all requests 0, fault=1, credit retained; FAULT exits only on RES.
REQ-031 Max credit SHALL be PRICE+3 (<=7); credit arithmetic SHALL never wrap.

Reset
REQ-032 RES high at a rising CLK edge SHALL force COLLECT, credit=0, wait counter=0, and guffin, quarter_out, halfDollar_out, coin_reject, fault, state_high, state_low all 0 on the next cycle.
REQ-033 RES SHALL take priority over every input and abort any in-progress VEND/CHANGE sequence without completing it.

Verification
REQ-034 PRICE=3: quarter, quarter, quarter pulses -> credit 1,2 then VEND; guffin high until ack; credit=0 -> COLLECT.
REQ-035 PRICE=3: dollar pulse -> VEND credit=1; ack -> CHANGE, quarter_out=1; ack -> credit=0, COLLECT.
REQ-036 halfDollar then cancel -> CHANGE, halfDollar_out=1 with credit=2; ack -> credit=0, COLLECT.
REQ-037 quarter_in and dollar_in same cycle -> coin_reject=1, credit stays 0; quarter during VEND -> coin_reject=1.
REQ-038 TIMEOUT=4, dollar pulse, no ack -> guffin high 4 cycles, then FAULT: fault=1, credit=1, state 11; RES -> all zero, COLLECT.
